gtp_common_pll_ctrl: RTL

Per-PLL power-up/reset sequencer for the GTP common block (one instance per PLL0/PLL1). It drives the PLL power-down, reset and lock-enable pins through a timed sequence, qualifies lock with a stability window and timeout, retries on failure, and re-locks automatically on loss of lock or reference clock. It sits between system reset/enable logic and the transceiver common tile, and reports READY/FAIL to the link-level controller.

---
 rtl/gtp_ctrl_pkg.sv | 37 +++
 rtl/gtp_sync2.sv | 36 +++
 rtl/gtp_common_pll_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/gtp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gtp_ctrl_pkg
// Description : Shared definitions for the GTP common PLL sequencers.
//               - state encoding, also used by the PLL1 instance and the
//                 debug register map
//               - clog2 helper for counter sizing
//               - synchroniser depth
// Revision    : 1.0  initial release
// ============================================================================
package gtp_ctrl_pkg;

  // Encodings are visible on the debug STATE port and in the register
  // map, so they must stay fixed.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PWRDN     = 3'd1,
    ST_RESET     = 3'd2,
    ST_WAIT_LOCK = 3'd3,
    ST_READY     = 3'd4,
    ST_FAIL      = 3'd5
  } pll_state_e;

  localparam int unsigned SYNC_STAGES = 2;

  // Ceiling log2; returns 0 for values 0 and 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gtp_sync2.sv
`default_nettype none
// ============================================================================
// Module      : gtp_sync2
// Description : Multi-flop synchroniser (depth SYNC_STAGES) for a single
//               asynchronous level into the control clock domain.
// Ports       : i_clk   control clock
//               i_rst_n asynchronous active-low reset
//               i_d     asynchronous input level
//               o_q     synchronised output
// Revision    : 1.0  initial release
// ============================================================================
module gtp_sync2
  import gtp_ctrl_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/gtp_common_pll_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gtp_common_pll_ctrl
// Description : Power-up / reset sequencer for one GTP common PLL. Drives
//               PLLPD, PLLRESET and PLLLOCKEN through a timed sequence,
//               qualifies lock with a stability window and a timeout,
//               retries on timeout and re-locks on lock / refclk loss.
// Ports       : i_clk            free-running control clock
//               i_rst_n          asynchronous active-low reset
//               i_start          rising edge starts from IDLE or FAIL
//               i_stop           level, forces IDLE while high
//               i_pll_lock       PLLxLOCK (asynchronous)
//               i_pll_refclklost PLLxREFCLKLOST (asynchronous)
//               o_pllpd          to PLLxPD
//               o_pllreset       to PLLxRESET
//               o_plllocken      to PLLxLOCKEN
//               o_ready          PLL locked and qualified
//               o_fail           retries exhausted
//               o_relock         one-cycle pulse on lock loss while READY
//               o_retry_cnt      timeouts since last start, saturating
//               o_state          current state encoding (debug)
// Revision    : 1.0  initial release
// ============================================================================
module gtp_common_pll_ctrl
  import gtp_ctrl_pkg::*;
#(
  parameter int unsigned PD_CYCLES    = 16,
  parameter int unsigned RESET_CYCLES = 16,
  parameter int unsigned LOCK_STABLE  = 32,
  parameter int unsigned LOCK_TIMEOUT = 1024,
  parameter int unsigned MAX_RETRIES  = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic       i_pll_lock,
  input  logic       i_pll_refclklost,
  output logic       o_pllpd,
  output logic       o_pllreset,
  output logic       o_plllocken,
  output logic       o_ready,
  output logic       o_fail,
  output logic       o_relock,
  output logic [3:0] o_retry_cnt,
  output logic [2:0] o_state
);

  // One counter width must hold the largest of all cycle parameters.
  localparam int unsigned C_MAX_A = (PD_CYCLES > RESET_CYCLES) ? PD_CYCLES : RESET_CYCLES;
  localparam int unsigned C_MAX_B = (LOCK_STABLE > LOCK_TIMEOUT) ? LOCK_STABLE : LOCK_TIMEOUT;
  localparam int unsigned C_MAX   = (C_MAX_A > C_MAX_B) ? C_MAX_A : C_MAX_B;
  localparam int unsigned CW      = clog2(C_MAX + 1);

  // Counters start at 0 on entry, so the last cycle in a state is N-1.
  localparam logic [CW-1:0] C_PD_LAST  = CW'(PD_CYCLES - 1);
  localparam logic [CW-1:0] C_RST_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] C_TMO_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] C_STABLE   = CW'(LOCK_STABLE);
  localparam logic [3:0]    C_MAX_RTY  = 4'(MAX_RETRIES);

  logic          w_lock_s;
  logic          w_lost_s;
  logic          w_start_edge;
  pll_state_e    w_nxt;
  logic [CW-1:0] w_cnt;
  logic [CW-1:0] w_stable;
  logic [3:0]    w_retry;
  logic          w_relock;
  logic          w_lock_ok;

  pll_state_e    r_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_stable;
  logic [3:0]    r_retry;
  logic          r_start_q;
  logic          r_pd;
  logic          r_rst;
  logic          r_locken;
  logic          r_ready;
  logic          r_fail;
  logic          r_relock;

  gtp_sync2 #(.RST_VAL(1'b0)) u_sync_lock (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_pll_lock),
    .o_q     (w_lock_s)
  );

  gtp_sync2 #(.RST_VAL(1'b0)) u_sync_lost (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_pll_refclklost),
    .o_q     (w_lost_s)
  );

  assign w_start_edge = i_start & ~r_start_q;
  // A lost reference clock disqualifies lock even if LOCK still reads high.
  assign w_lock_ok    = w_lock_s & ~w_lost_s;

  always_comb begin
    w_nxt    = r_state;
    w_cnt    = '0;
    w_stable = '0;
    w_retry  = r_retry;
    w_relock = 1'b0;
    if (i_stop) begin
      w_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_FAIL: begin
          if (w_start_edge) begin
            w_retry = '0;
            w_nxt   = ST_PWRDN;
          end
        end
        ST_PWRDN: begin
          w_cnt = r_cnt + 1'b1;
          if (r_cnt == C_PD_LAST) w_nxt = ST_RESET;
        end
        ST_RESET: begin
          w_cnt = r_cnt + 1'b1;
          if (r_cnt == C_RST_LAST) w_nxt = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          w_cnt = r_cnt + 1'b1;
          if (w_lock_ok) w_stable = r_stable + 1'b1;
          // Stability is checked first so a simultaneous timeout still locks.
          if (w_stable == C_STABLE) begin
            w_nxt = ST_READY;
          end else if (r_cnt == C_TMO_LAST) begin
            if (r_retry < C_MAX_RTY) begin
              w_retry = (r_retry == 4'hF) ? r_retry : r_retry + 1'b1;
              w_nxt   = ST_PWRDN;
            end else begin
              w_nxt = ST_FAIL;
            end
          end
        end
        ST_READY: begin
          if (!w_lock_s || w_lost_s) begin
            w_relock = 1'b1;
            w_nxt    = ST_RESET;
          end
        end
        default: w_nxt = ST_IDLE;
      endcase
    end
    if (w_nxt != r_state) begin
      w_cnt    = '0;
      w_stable = '0;
    end
  end

  // Outputs are decoded from the next state so they line up with STATE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_stable  <= '0;
      r_retry   <= '0;
      r_start_q <= 1'b0;
      r_pd      <= 1'b1;
      r_rst     <= 1'b1;
      r_locken  <= 1'b0;
      r_ready   <= 1'b0;
      r_fail    <= 1'b0;
      r_relock  <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_cnt     <= w_cnt;
      r_stable  <= w_stable;
      r_retry   <= w_retry;
      r_start_q <= i_start;
      r_pd      <= (w_nxt == ST_IDLE) || (w_nxt == ST_PWRDN) || (w_nxt == ST_FAIL);
      r_rst     <= (w_nxt == ST_IDLE) || (w_nxt == ST_PWRDN) || (w_nxt == ST_RESET) ||
                   (w_nxt == ST_FAIL);
      r_locken  <= (w_nxt == ST_WAIT_LOCK) || (w_nxt == ST_READY);
      r_ready   <= (w_nxt == ST_READY);
      r_fail    <= (w_nxt == ST_FAIL);
      r_relock  <= w_relock;
    end
  end

  assign o_pllpd     = r_pd;
  assign o_pllreset  = r_rst;
  assign o_plllocken = r_locken;
  assign o_ready     = r_ready;
  assign o_fail      = r_fail;
  assign o_relock    = r_relock;
  assign o_retry_cnt = r_retry;
  assign o_state     = r_state;

endmodule
`default_nettype wire
